// File: rtl/pipe_rr_arb.sv
// Round-robin arbiter over N_REQ producers feeding one registered valid/ready stage.
// Optional PIPE_RR_ARB_LOCK_EN adds req_lock so a winner can hold the grant across beats.
module pipe_rr_arb #(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
`ifdef PIPE_RR_ARB_LOCK_EN
    input  logic [N_REQ-1:0]            req_lock,
`endif
    output logic [N_REQ-1:0]            req_ready,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [ID_WIDTH-1:0]         out_id,
    input  logic                        out_ready
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [IW-1:0]         last_grant;

    logic [DATA_WIDTH-1:0] req_arr [N_REQ];
    logic [N_REQ-1:0]      eligible;
    logic [IW-1:0]         winner;
    logic                  any_win;
    logic                  accept;
    logic                  fire;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef PIPE_RR_ARB_LOCK_EN
    logic          locked;
    logic [IW-1:0] lock_id;

    // While locked, only the lock holder is a candidate.
    always_comb begin
        eligible = req_valid;
        if (locked)
            eligible = req_valid & (N_REQ'(1) << lock_id);
    end
`else
    assign eligible = req_valid;
`endif

    // Scan from last_grant+1 upward; descending loop so the nearest candidate is written last.
    always_comb begin
        int idx;
        idx     = 0;
        winner  = '0;
        any_win = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (eligible[idx]) begin
                winner  = IW'(idx);
                any_win = 1'b1;
            end
        end
    end

    assign accept    = ~rst & (~valid_q | out_ready);
    assign fire      = accept & any_win;
    assign req_ready = fire ? (N_REQ'(1) << winner) : '0;

    assign out_valid = valid_q;
    assign out_data  = valid_q ? data_q : '0;
    assign out_id    = valid_q ? id_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            id_q       <= '0;
            last_grant <= IW'(N_REQ - 1);
        end else begin
            if (fire) begin
                valid_q <= 1'b1;
                data_q  <= req_arr[winner];
                id_q    <= ID_WIDTH'(winner);
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
`ifndef PIPE_RR_ARB_LOCK_EN
            if (fire)
                last_grant <= winner;
`else
            if (fire) begin
                if (!locked)
                    last_grant <= winner;
                else if (!req_lock[winner])
                    last_grant <= winner;
            end
`endif
        end
    end

`ifdef PIPE_RR_ARB_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked  <= 1'b0;
            lock_id <= '0;
        end else if (fire) begin
            if (!locked && req_lock[winner]) begin
                locked  <= 1'b1;
                lock_id <= winner;
            end else if (locked && !req_lock[winner]) begin
                locked  <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_rr_arb.sv
// Directed bench for pipe_rr_arb (N_REQ=2): expected beats queued by the driver,
// popped and compared by a monitor whenever a beat leaves the stage.
module tb_pipe_rr_arb;

    localparam int N   = 2;
    localparam int DW  = 32;
    localparam int IDW = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic [IDW-1:0] out_id;
    logic           out_ready;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    errors = 0;
    int    checks = 0;

    pipe_rr_arb #(.N_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef PIPE_RR_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [IDW-1:0] id, input logic [DW-1:0] data);
        exp_q.push_back('{id: id, data: data});
    endtask

    // Drive one cycle's inputs just after the edge, then let combinational outputs settle.
    task automatic step(input logic [N-1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic ordy, input logic [N-1:0] lk);
        @(posedge clk);
        #1;
        req_valid = v;
        req_data  = {d1, d0};
        out_ready = ordy;
        req_lock  = lk;
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got id=%0d data=%0h expected none", out_id, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_id !== mon_e.id || out_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL beat: got id=%0d data=%0h expected id=%0d data=%0h",
                             out_id, out_data, mon_e.id, mon_e.data);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        req_data  = {32'hB0, 32'hA0};
        req_lock  = '0;
        out_ready = 1'b1;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_data",  out_data,  0);
        chk("rst_id",    out_id,    0);
        chk("rst_ready", req_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 2'b00;
        @(posedge clk);
        #2;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_data",  out_data,  0);
        chk("post_rst_ready", req_ready, 0);

        // Both valid: strict alternation starting at 0 (last_grant resets to N-1).
        step(2'b11, 32'hA0, 32'hB0, 1'b1, 2'b00); chk("rr_ready0", req_ready, 2'b01); push(0, 32'hA0);
        step(2'b11, 32'hA0, 32'hB0, 1'b1, 2'b00); chk("rr_ready1", req_ready, 2'b10); push(1, 32'hB0);
        step(2'b11, 32'hA0, 32'hB0, 1'b1, 2'b00); chk("rr_ready2", req_ready, 2'b01); push(0, 32'hA0);
        step(2'b11, 32'hA0, 32'hB0, 1'b1, 2'b00); chk("rr_ready3", req_ready, 2'b10); push(1, 32'hB0);

        // Only req1 three times, then both: req0 next.
        step(2'b10, 32'h0, 32'h11, 1'b1, 2'b00); chk("solo1_ready", req_ready, 2'b10); push(1, 32'h11);
        step(2'b10, 32'h0, 32'h12, 1'b1, 2'b00); push(1, 32'h12);
        step(2'b10, 32'h0, 32'h13, 1'b1, 2'b00); push(1, 32'h13);
        step(2'b11, 32'h20, 32'h21, 1'b1, 2'b00); chk("after_solo_ready", req_ready, 2'b01); push(0, 32'h20);

        // Stall with 0x55 held in the stage.
        step(2'b01, 32'h55, 32'h0, 1'b1, 2'b00); chk("load55_ready", req_ready, 2'b01); push(0, 32'h55);
        for (int c = 0; c < 4; c++) begin
            step(2'b10, 32'h0, 32'h66, 1'b0, 2'b00);
            chk("stall_ready", req_ready, 2'b00);
            chk("stall_data",  out_data,  32'h55);
            chk("stall_valid", out_valid, 1);
        end
        step(2'b10, 32'h0, 32'h66, 1'b1, 2'b00); chk("unstall_ready", req_ready, 2'b10); push(1, 32'h66);

        // Drain, then confirm priority did not rotate on idle cycles.
        step(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);
        step(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);
        chk("drain_valid", out_valid, 0);
        chk("drain_data",  out_data,  0);
        chk("drain_id",    out_id,    0);
        step(2'b11, 32'h77, 32'h78, 1'b1, 2'b00); chk("idle_keep_ready", req_ready, 2'b01); push(0, 32'h77);
        step(2'b10, 32'h0, 32'h78, 1'b1, 2'b00); chk("next_ready", req_ready, 2'b10); push(1, 32'h78);

`ifdef PIPE_RR_ARB_LOCK_EN
        // req0 locks out req1 until it sends a beat with lock low.
        step(2'b11, 32'h80, 32'h90, 1'b1, 2'b01); chk("lock_ready0", req_ready, 2'b01); push(0, 32'h80);
        step(2'b11, 32'h81, 32'h90, 1'b1, 2'b01); chk("lock_ready1", req_ready, 2'b01); push(0, 32'h81);
        step(2'b11, 32'h82, 32'h90, 1'b1, 2'b00); chk("lock_ready2", req_ready, 2'b01); push(0, 32'h82);
        step(2'b11, 32'h83, 32'h90, 1'b1, 2'b00); chk("unlock_ready", req_ready, 2'b10); push(1, 32'h90);
`endif

        step(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);
        step(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);
        step(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);
        chk("queue_empty", exp_q.size(), 0);

        // Reset while a beat sits in the stage: it must vanish immediately.
        step(2'b01, 32'h99, 32'h0, 1'b0, 2'b00);
        step(2'b00, 32'h0, 32'h0, 1'b0, 2'b00);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_data",  out_data,  32'h99);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data",  out_data,  0);
        chk("mid_rst_ready", req_ready, 0);
        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
